// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bundle: two writeback requesters in, one
// registered register-file write port plus debug out.
interface regfile_wport_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          VALID0;
  logic [AW-1:0] ADDR0;
  logic [DW-1:0] DATA0;
  logic          READY0;
  logic          VALID1;
  logic [AW-1:0] ADDR1;
  logic [DW-1:0] DATA1;
  logic          READY1;
  logic          SEL;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic          STALL0;
  logic [1:0]    WAIT_CNT;

  modport master (
    output VALID0, ADDR0, DATA0,
    output VALID1, ADDR1, DATA1,
    input  READY0, READY1, SEL, WE,
    input  WADDR, WDATA, STALL0, WAIT_CNT
  );

  modport slave (
    input  VALID0, ADDR0, DATA0,
    input  VALID1, ADDR1, DATA1,
    output READY0, READY1, SEL, WE,
    output WADDR, WDATA, STALL0, WAIT_CNT
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between the ALU (req 0)
// and load return (req 1): fixed priority to req 0 with aging.
// Ports: CLK, RST (sync, active-high), bus (slave modport):
//   VALIDi/ADDRi/DATAi in, READYi out (comb), STALL0 out,
//   SEL/WE/WADDR/WDATA registered write port, WAIT_CNT debug.
module regfile_wport_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 3
) (
  input logic                    CLK,
  input logic                    RST,
  regfile_wport_arbiter_if.slave bus
);
  localparam logic [1:0] MW = 2'(MAX_WAIT);

  logic          g0;
  logic          g1;
  logic          aged;
  logic [1:0]    wait_cnt;
  logic          we_q;
  logic          sel_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  // Aged req 1 beats req 0; otherwise req 1 only
  // wins when req 0 is idle.
  always_comb begin
    aged = bus.VALID1 && (wait_cnt >= MW);
    g1   = !RST && bus.VALID1
           && (aged || !bus.VALID0);
    g0   = !RST && bus.VALID0 && !g1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (g1 || !bus.VALID1) begin
      wait_cnt <= '0;
    end else if (wait_cnt < MW) begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // r0 writes are accepted but never raise WE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (g0) begin
      we_q    <= |bus.ADDR0;
      sel_q   <= 1'b0;
      waddr_q <= bus.ADDR0;
      wdata_q <= bus.DATA0;
    end else if (g1) begin
      we_q    <= |bus.ADDR1;
      sel_q   <= 1'b1;
      waddr_q <= bus.ADDR1;
      wdata_q <= bus.DATA1;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign bus.READY0   = g0;
  assign bus.READY1   = g1;
  assign bus.STALL0   = !RST && bus.VALID0 && !g0;
  assign bus.WAIT_CNT = wait_cnt;
  assign bus.WE       = we_q;
  assign bus.SEL      = sel_q;
  assign bus.WADDR    = waddr_q;
  assign bus.WDATA    = wdata_q;
endmodule
